// File: rtl/alu_pkg.sv
// Shared constants and types for the 8-bit ALU add/subtract datapath.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NIB_W  = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/add_4bit.sv
// 4-bit carry-lookahead nibble adder; purely combinational.
module add_4bit
    import alu_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W-1:0] w_g;
    logic [NIB_W-1:0] w_p;
    logic [NIB_W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Flattened lookahead carries so every carry is two levels from g/p.
    always_comb begin
        w_c[0] = cin;
        w_c[1] = w_g[0] | (w_p[0] & cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & cin);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
    end

    assign sum  = w_p ^ w_c[NIB_W-1:0];
    assign cout = w_c[NIB_W];

endmodule

// File: rtl/alu_add8_seq.sv
// Sequential 8-bit add/subtract: one nibble CLA time-shared over LO/HI cycles,
// with a persistent carry flag for ADC/SBC chaining.
module alu_add8_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_v,
    output logic              flag_z,
    output logic              flag_n
);

    state_t            r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_bx;
    logic              r_cin;
    logic              r_use_cq;
    logic              r_carry_q;
    logic [NIB_W-1:0]  r_s_lo;
    logic              r_c_lo;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_flag_c;
    logic              r_flag_v;
    logic              r_flag_z;
    logic              r_flag_n;

    logic [NIB_W-1:0]  w_na;
    logic [NIB_W-1:0]  w_nb;
    logic              w_ncin;
    logic [NIB_W-1:0]  w_sum;
    logic              w_cout;
    logic [DATA_W-1:0] w_res;
    logic              w_is_sub;

    assign w_is_sub = (op == OP_SUB) || (op == OP_SBC);

    // Operand muxes: low nibble in LO, high nibble plus registered carry in HI.
    assign w_na   = (r_state == HI) ? r_a[DATA_W-1:NIB_W]  : r_a[NIB_W-1:0];
    assign w_nb   = (r_state == HI) ? r_bx[DATA_W-1:NIB_W] : r_bx[NIB_W-1:0];
    assign w_ncin = (r_state == HI) ? r_c_lo : (r_use_cq ? r_carry_q : r_cin);

    add_4bit u_add (
        .a    (w_na),
        .b    (w_nb),
        .cin  (w_ncin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_res = {w_sum, r_s_lo};

    // Control FSM and all datapath/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_bx        <= '0;
            r_cin       <= 1'b0;
            r_use_cq    <= 1'b0;
            r_carry_q   <= 1'b0;
            r_s_lo      <= '0;
            r_c_lo      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_n    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_bx       <= w_is_sub ? ~b : b;
                        r_cin      <= (op == OP_SUB);
                        r_use_cq   <= (op == OP_ADC) || (op == OP_SBC);
                        r_in_ready <= 1'b0;
                        r_state    <= LO;
                    end
                end
                LO: begin
                    r_s_lo  <= w_sum;
                    r_c_lo  <= w_cout;
                    r_state <= HI;
                end
                HI: begin
                    r_result    <= w_res;
                    r_flag_c    <= w_cout;
                    r_flag_v    <= (r_a[DATA_W-1] == r_bx[DATA_W-1]) &&
                                   (w_res[DATA_W-1] != r_a[DATA_W-1]);
                    r_flag_z    <= (w_res == '0);
                    r_flag_n    <= w_res[DATA_W-1];
                    r_carry_q   <= w_cout;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;
    assign flag_z    = r_flag_z;
    assign flag_n    = r_flag_n;

endmodule
